// File: rtl/multi_flux_fifo.sv
// Tagged multi-flux FWFT channel buffer: one queue per flux,
// writes routed by tag, per-flux flags, single tagged head bus.
module multi_flux_fifo #(
  parameter int FLUX = 2,
  parameter int DATA_WIDTH = 27,
  parameter int DEPTH = 4,
  localparam int TAG_WIDTH = $clog2(FLUX),
  localparam int WIDTH = DATA_WIDTH + TAG_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write,
  input  logic [WIDTH-1:0] din,
  output logic [FLUX-1:0]  full,
  input  logic [FLUX-1:0]  read,
  output logic [FLUX-1:0]  empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [FLUX][DEPTH];
  logic [AW-1:0] wr_ptr [FLUX];
  logic [AW-1:0] rd_ptr [FLUX];
  logic [CW-1:0] count [FLUX];

  logic [TAG_WIDTH-1:0]  tag;
  logic [DATA_WIDTH-1:0] payload;
  logic [FLUX-1:0]       wr_en;
  logic [FLUX-1:0]       rd_en;

  assign tag     = din[WIDTH-1:DATA_WIDTH];
  assign payload = din[DATA_WIDTH-1:0];

  // Flags come only from registered counts, so read/write never
  // feed back combinationally into empty/full.
  always_comb begin
    empty = '0;
    full  = '0;
    wr_en = '0;
    rd_en = '0;
    for (int i = 0; i < FLUX; i++) begin
      empty[i] = (count[i] == '0);
      full[i]  = (count[i] == CW'(DEPTH));
      wr_en[i] = write && (tag == TAG_WIDTH'(i)) && !full[i];
      rd_en[i] = read[i] && !empty[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FLUX; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < FLUX; i++) begin
        if (wr_en[i])
          wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (rd_en[i])
          rd_ptr[i] <= rd_ptr[i] + AW'(1);
        if (wr_en[i] && !rd_en[i])
          count[i] <= count[i] + CW'(1);
        else if (!wr_en[i] && rd_en[i])
          count[i] <= count[i] - CW'(1);
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FLUX; i++) begin
      if (!rst && wr_en[i])
        mem[i][wr_ptr[i]] <= payload;
    end
  end

  logic [TAG_WIDTH-1:0] sel;
  logic                 any;

  always_comb begin
    sel = '0;
    any = (|read) || !(&empty);
    if (|read) begin
      for (int i = FLUX - 1; i >= 0; i--)
        if (read[i]) sel = TAG_WIDTH'(i);
    end else begin
      for (int i = FLUX - 1; i >= 0; i--)
        if (!empty[i]) sel = TAG_WIDTH'(i);
    end
  end

  assign dout = any ? {sel, mem[sel][rd_ptr[sel]]} : '0;

endmodule

// File: tb/tb_multi_flux_fifo.sv
// Bench for multi_flux_fifo: directed vector table, corner
// sequences and random traffic against a queue-based model.
module tb_multi_flux_fifo;

  localparam int DW = 27;
  localparam int W  = 28;

  logic          clk = 1'b0;
  logic          rst;
  logic          write;
  logic [W-1:0]  din;
  logic [1:0]    full;
  logic [1:0]    read;
  logic [1:0]    empty;
  logic [W-1:0]  dout;

  int nvec = 0;
  int nfail = 0;

  logic [DW-1:0] mq [2][$];

  multi_flux_fifo dut (
    .clk(clk), .rst(rst), .write(write), .din(din),
    .full(full), .read(read), .empty(empty), .dout(dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         r;
    logic         w;
    logic [W-1:0] d;
    logic [1:0]   rd;
    logic [1:0]   ee;
    logic [1:0]   ef;
    logic [W-1:0] ed;
    bit           cd;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle, compare against the model (and optional
  // table constants) before the edge, then advance the model.
  task automatic apply(input logic r, input logic w,
                       input logic [W-1:0] d, input logic [1:0] rd,
                       input bit use_exp, input vec_t v);
    logic [1:0]   me, mf;
    logic [W-1:0] md;
    bit           known;
    int           sel;
    bit           wacc;
    int           wt;
    @(negedge clk);
    rst = r; write = w; din = d; read = rd;
    #1;
    for (int i = 0; i < 2; i++) begin
      me[i] = (mq[i].size() == 0);
      mf[i] = (mq[i].size() == 4);
    end
    known = 1'b1;
    md = '0;
    if (rd != 0) sel = rd[0] ? 0 : 1;
    else sel = (mq[0].size() != 0) ? 0 : 1;
    if (rd != 0 || me != 2'b11) begin
      if (mq[sel].size() != 0) md = {sel[0], mq[sel][0]};
      else known = 1'b0;
    end
    chk("empty", W'(empty), W'(me));
    chk("full", W'(full), W'(mf));
    if (known) chk("dout", dout, md);
    if (use_exp) begin
      chk("tbl_empty", W'(empty), W'(v.ee));
      chk("tbl_full", W'(full), W'(v.ef));
      if (v.cd) chk("tbl_dout", dout, v.ed);
    end
    @(posedge clk);
    if (r) begin
      mq[0].delete();
      mq[1].delete();
    end else begin
      wt = int'(d[W-1]);
      wacc = w && (mq[wt].size() < 4);
      for (int i = 0; i < 2; i++)
        if (rd[i] && mq[i].size() != 0) void'(mq[i].pop_front());
      if (wacc) mq[wt].push_back(d[DW-1:0]);
    end
  endtask

  function automatic logic [W-1:0] tk(input int t, input int p);
    logic [W-1:0] x;
    x = {t[0], p[DW-1:0]};
    return x;
  endfunction

  task automatic add(input logic w, input logic [W-1:0] d,
                     input logic [1:0] rd, input logic [1:0] ee,
                     input logic [1:0] ef, input logic [W-1:0] ed,
                     input bit cd);
    vec_t v;
    v.r = 1'b0; v.w = w; v.d = d; v.rd = rd;
    v.ee = ee; v.ef = ef; v.ed = ed; v.cd = cd;
    tbl.push_back(v);
  endtask

  vec_t nv;

  initial begin
    nv = '{default: '0};
    rst = 1'b1; write = 1'b0; din = '0; read = '0;
    repeat (2) @(posedge clk);
    // Flux 0 basic FWFT
    add(1, tk(0, 5), 2'b00, 2'b11, 2'b00, tk(0, 0), 1);
    add(1, tk(0, 7), 2'b00, 2'b10, 2'b00, tk(0, 5), 1);
    add(0, tk(0, 0), 2'b00, 2'b10, 2'b00, tk(0, 5), 1);
    add(0, tk(0, 0), 2'b01, 2'b10, 2'b00, tk(0, 5), 1);
    add(0, tk(0, 0), 2'b01, 2'b10, 2'b00, tk(0, 7), 1);
    add(0, tk(0, 0), 2'b00, 2'b11, 2'b00, tk(0, 0), 1);
    // Flux 1 fill to full, drop 99, drain in order
    add(1, tk(1, 10), 2'b00, 2'b11, 2'b00, tk(0, 0), 1);
    add(1, tk(1, 11), 2'b00, 2'b01, 2'b00, tk(1, 10), 1);
    add(1, tk(1, 12), 2'b00, 2'b01, 2'b00, tk(1, 10), 1);
    add(1, tk(1, 13), 2'b00, 2'b01, 2'b00, tk(1, 10), 1);
    add(1, tk(1, 99), 2'b00, 2'b01, 2'b10, tk(1, 10), 1);
    add(0, tk(0, 0), 2'b00, 2'b01, 2'b10, tk(1, 10), 1);
    add(0, tk(0, 0), 2'b10, 2'b01, 2'b10, tk(1, 10), 1);
    add(0, tk(0, 0), 2'b10, 2'b01, 2'b00, tk(1, 11), 1);
    add(0, tk(0, 0), 2'b10, 2'b01, 2'b00, tk(1, 12), 1);
    add(0, tk(0, 0), 2'b10, 2'b01, 2'b00, tk(1, 13), 1);
    add(0, tk(0, 0), 2'b00, 2'b11, 2'b00, tk(0, 0), 1);
    // Simultaneous push/pop on non-empty flux 0
    add(1, tk(0, 1), 2'b00, 2'b11, 2'b00, tk(0, 0), 1);
    add(1, tk(0, 3), 2'b01, 2'b10, 2'b00, tk(0, 1), 1);
    add(0, tk(0, 0), 2'b00, 2'b10, 2'b00, tk(0, 3), 1);
    add(0, tk(0, 0), 2'b01, 2'b10, 2'b00, tk(0, 3), 1);
    add(0, tk(0, 0), 2'b00, 2'b11, 2'b00, tk(0, 0), 1);
    // Push with read on empty flux 1: no bypass
    add(1, 28'hFFFFFFF, 2'b10, 2'b11, 2'b00, tk(0, 0), 0);
    add(0, tk(0, 0), 2'b00, 2'b01, 2'b00, 28'hFFFFFFF, 1);
    add(0, tk(0, 0), 2'b10, 2'b01, 2'b00, 28'hFFFFFFF, 1);
    add(0, tk(0, 0), 2'b00, 2'b11, 2'b00, tk(0, 0), 1);
    foreach (tbl[k])
      apply(tbl[k].r, tbl[k].w, tbl[k].d, tbl[k].rd, 1'b1, tbl[k]);

    // Flux 0 full, alternate pushes across fluxes, pop alternately
    for (int k = 0; k < 4; k++)
      apply(0, 1, tk(0, 100 + k), 2'b00, 0, nv);
    for (int k = 0; k < 20; k++)
      apply(0, 1, tk(k % 2, 200 + k),
            (k % 2 == 0) ? 2'b01 : 2'b10, 0, nv);
    for (int k = 0; k < 8; k++)
      apply(0, 0, '0, (k % 2 == 0) ? 2'b01 : 2'b10, 0, nv);

    // Reset mid-stream with a write in the reset cycle
    for (int k = 0; k < 6; k++)
      apply(0, 1, tk(k % 2, 300 + k), 2'b00, 0, nv);
    apply(1, 1, tk(0, 55), 2'b00, 0, nv);
    nv.ee = 2'b11; nv.ef = 2'b00; nv.ed = '0; nv.cd = 1'b1;
    apply(0, 0, '0, 2'b00, 1, nv);
    nv = '{default: '0};

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      logic [1:0] rd;
      int rr;
      rr = $urandom_range(0, 2);
      rd = (rr == 0) ? 2'b00 : (rr == 1) ? 2'b01 : 2'b10;
      apply(($urandom_range(0, 199) == 0), $urandom_range(0, 1) == 1,
            tk($urandom_range(0, 1), $urandom), rd, 0, nv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
